// File: rtl/stopwatch_display.sv
// Snapshots the stopwatch time bus once per refresh period, converts each field to BCD
// with a shared shift-add-3 engine and commits all nine digits plus HEX patterns at once.
module stopwatch_display #(
    parameter int unsigned REFRESH_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] epoch,
    input  logic [9:0]  m_epoch,
    input  logic        hold,
    output logic [35:0] bcd,
    output logic [62:0] segments,
    output logic        busy,
    output logic        update
);

    localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_STORE  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    // Field order of conversion: 0 = ms, 1 = second, 2 = minute, 3 = hour.
    localparam logic [1:0] F_MS   = 2'd0;
    localparam logic [1:0] F_SEC  = 2'd1;
    localparam logic [1:0] F_MIN  = 2'd2;
    localparam logic [1:0] F_HOUR = 2'd3;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [CW-1:0] count_q;
    state_t        state_q;
    logic [1:0]    field_q;
    logic [3:0]    shift_cnt_q;
    logic [17:0]   snap_epoch_q;
    logic [9:0]    snap_ms_q;
    logic [9:0]    bin_q;
    logic [15:0]   acc_q;
    logic [35:0]   dig_q;
    logic [35:0]   bcd_q;
    logic [62:0]   seg_q;
    logic          busy_q;
    logic          update_q;

    logic          tick_s;
    logic [9:0]    load_val_s;
    logic [15:0]   acc_adj_s;
    logic [15:0]   acc_shift_d;
    logic [9:0]    bin_shift_d;
    logic [62:0]   seg_d;

    assign tick_s = (count_q == CNT_LAST);

    // Free-running refresh counter; wraps every REFRESH_CYCLES cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (tick_s) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_ONE;
        end
    end

    // Select the snapshot field for the current conversion; ms is clamped to 999.
    always_comb begin
        load_val_s = 10'd0;
        case (field_q)
            F_MS: begin
                if (snap_ms_q > 10'd999) begin
                    load_val_s = 10'd999;
                end else begin
                    load_val_s = snap_ms_q;
                end
            end
            F_SEC:   load_val_s = {4'd0, snap_epoch_q[5:0]};
            F_MIN:   load_val_s = {4'd0, snap_epoch_q[11:6]};
            F_HOUR:  load_val_s = {4'd0, snap_epoch_q[17:12]};
            default: load_val_s = 10'd0;
        endcase
    end

    // One double-dabble step: correct nibbles >= 5, then shift {acc, bin} left.
    always_comb begin
        acc_adj_s = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj_s[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end else begin
                acc_adj_s[i*4 +: 4] = acc_q[i*4 +: 4];
            end
        end
        {acc_shift_d, bin_shift_d} = {acc_adj_s, bin_q} << 1;
    end

    // Seven-segment image of the holding registers, loaded only at commit.
    always_comb begin
        seg_d = '1;
        for (int i = 0; i < 9; i++) begin
            seg_d[i*7 +: 7] = seg7(dig_q[i*4 +: 4]);
        end
    end

    // Conversion sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            field_q      <= F_MS;
            shift_cnt_q  <= 4'd0;
            snap_epoch_q <= 18'd0;
            snap_ms_q    <= 10'd0;
            bin_q        <= 10'd0;
            acc_q        <= 16'd0;
            dig_q        <= 36'd0;
            bcd_q        <= 36'd0;
            seg_q        <= '1;
            busy_q       <= 1'b0;
            update_q     <= 1'b0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick_s && !hold) begin
                        snap_epoch_q <= epoch;
                        snap_ms_q    <= m_epoch;
                        field_q      <= F_MS;
                        busy_q       <= 1'b1;
                        state_q      <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    bin_q       <= load_val_s;
                    acc_q       <= 16'd0;
                    shift_cnt_q <= 4'd0;
                    state_q     <= S_SHIFT;
                end
                S_SHIFT: begin
                    acc_q       <= acc_shift_d;
                    bin_q       <= bin_shift_d;
                    shift_cnt_q <= shift_cnt_q + 4'd1;
                    if (shift_cnt_q == 4'd9) begin
                        state_q <= S_STORE;
                    end else begin
                        state_q <= S_SHIFT;
                    end
                end
                S_STORE: begin
                    case (field_q)
                        F_MS:    dig_q[11:0]  <= acc_q[11:0];
                        F_SEC:   dig_q[19:12] <= acc_q[7:0];
                        F_MIN:   dig_q[27:20] <= acc_q[7:0];
                        F_HOUR:  dig_q[35:28] <= acc_q[7:0];
                        default: dig_q        <= dig_q;
                    endcase
                    if (field_q == F_HOUR) begin
                        state_q <= S_COMMIT;
                    end else begin
                        field_q <= field_q + 2'd1;
                        state_q <= S_LOAD;
                    end
                end
                S_COMMIT: begin
                    bcd_q    <= dig_q;
                    seg_q    <= seg_d;
                    busy_q   <= 1'b0;
                    update_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bcd      = bcd_q;
    assign segments = seg_q;
    assign busy     = busy_q;
    assign update   = update_q;

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Display-side consumer of the stopwatch time bus. Periodically snapshots `epoch` {hour, minute, second} and `m_epoch` (milliseconds) and converts each field to BCD with one shared iterative shift-add-3 engine. Commits nine digits atomically as BCD and active-low seven-segment patterns for the board HEX displays. Sits between the stopwatch core and the HEX pins.

## Interface
- `REFRESH_CYCLES`, 50000, clock cycles between snapshot ticks (1 ms at 50 MHz); legal range ≥ 64.
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `epoch`  in  18  {hour[17:12], minute[11:6], second[5:0]}, unsigned binary.
- `m_epoch`  in  10  milliseconds, unsigned binary.
- `hold`  in  1  when high at a tick, the snapshot is skipped and the display is frozen.
- `bcd`  out  36  {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones, ms_hund, ms_tens, ms_ones}, 4 bits each.
- `segments`  out  63  seven-segment patterns in the same digit order, 7 bits each, `ms_ones` at [6:0].
- `busy`  out  1  high from the capture edge until the commit edge.
- `update`  out  1  one-cycle pulse after each commit.

## Operation
- Refresh counter runs 0..REFRESH_CYCLES-1 and wraps. A tick occurs in the cycle where count == REFRESH_CYCLES-1.
- Tick with state IDLE and `hold` low: capture `epoch` and `m_epoch` into snapshot registers on the same edge, then enter LOAD for field ms.
- Tick with `hold` high, or with state not IDLE: tick ignored; no snapshot, outputs unchanged.
- States: IDLE -> (LOAD -> SHIFT×10 -> STORE) for ms, second, minute, hour in that order -> COMMIT -> IDLE.
- LOAD: 10-bit shift register <= field value, zero-extended; 16-bit BCD accumulator <= 0; shift count <= 0.
  - ms snapshot > 999 is clamped to 999 at LOAD.
  - hour, minute and second are displayed as-is (0..63); no range check.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {bcd_acc, bin} left by one.
  - Increment count; leave after the 10th shift.
- STORE: write the accumulator's low nibbles to that field's digit holding registers.
  - ms: 3 digits.
  - Others: 2 digits (upper nibbles are 0 by construction).
- COMMIT: on the exit edge, `bcd` and `segments` load from the holding registers, and `update` is set for one cycle.
- Segment encoding is active-low, bit0 = a … bit6 = g:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10 (hex).
  - Any nibble > 9 encodes as 7F (blank); unreachable in correct operation.
- `hold` changing mid-conversion has no effect; an in-flight conversion always commits.
- Inputs changing after capture have no effect on the in-flight result.

## Timing
- Reset values (asynchronous, while `reset` low):
  - `segments` = all ones (blank); `bcd` = 0; `busy` = 0; `update` = 0.
  - State IDLE; refresh counter 0; snapshot and holding registers 0.
- After reset release, the first tick is REFRESH_CYCLES cycles later.
- Capture edge E0: `busy` goes high after E0.
- Conversion takes 4 fields × 12 cycles + 1 COMMIT.
- `bcd`/`segments` change on edge E0+49. `busy` falls and `update` rises on that edge; `update` falls on E0+50.
- Outputs are fully registered and change only on the commit edge: no partially updated digit sets are ever visible.
- Reset asserted mid-conversion: immediate blank per the reset values; no `update` pulse for the aborted conversion.

## Test plan
- Reset: hold `reset` low 5 cycles with `epoch`, `m_epoch` nonzero -> `segments` = all ones, `bcd` = 0, `busy` = 0, `update` never pulses.
- Basic conversion (REFRESH_CYCLES = 100):
  - Stimulus: `epoch` = {12, 34, 56}, `m_epoch` = 789.
  - Required: `busy` high after capture edge; at E0+49 `bcd` = 0x123456789.
  - Required: `segments` digit h_tens = 79, ms_ones = 10; single-cycle `update`.
- Clamp: `m_epoch` = 1000, then 1023 on successive refreshes -> ms digits 9,9,9 both times.
- Clamp boundary: `m_epoch` = 999 -> 9,9,9; `m_epoch` = 0 -> 0,0,0 (segments 40).
- Snapshot coherence: change `epoch` to {1, 2, 3} at E0+10 -> committed value still reflects the E0 snapshot; the next refresh shows 010203.
- Hold: `hold` high spanning a tick -> no `busy`, no `update`, outputs unchanged. `hold` rising at E0+5 -> that conversion still commits at E0+49.
- Reset mid-conversion: assert `reset` at E0+20 for 3 cycles -> outputs blank immediately, `busy` 0. After release, the next `update` occurs exactly REFRESH_CYCLES+49 edges later.
